// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/D memory port arbiter: FSM state encoding,
// owner identifiers and the grant-selection helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // On a tie, rr=1 favours whoever was not served last; rr=0 always favours D.
  function automatic logic pick_owner(input logic if_req, input logic d_req,
                                      input logic rr, input logic last_owner);
    if (if_req && d_req) begin
      return rr ? ~last_owner : OWN_D;
    end
    return d_req ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Watchdog counter for the arbiter WAIT state: cleared while idle,
// counts WAIT cycles and flags the cycle in which the count reaches TIMEOUT.
module arb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != CW'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looks at the post-increment value so the abort lands after exactly TIMEOUT WAIT cycles.
  assign expired = en && (count_d == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF, D) arbiter for a single-ported memory with registered
// strobes and a WAIT watchdog. Define ARB_ROUND_ROBIN_EN for alternating tie-break.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic          grant;
  logic          tmr_expired;

  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_IDLE),
    .en      (state_q == ST_WAIT),
    .expired (tmr_expired)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  assign grant = pick_owner(if_req, d_req, 1'b1, last_owner_q);

  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_q == ST_IDLE) && (if_req || d_req)) begin
      last_owner_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= OWN_D;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign grant = pick_owner(if_req, d_req, 1'b0, OWN_D);
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          owner_d  = grant;
          mem_en_d = 1'b1;
          state_d  = ST_WAIT;
          if (grant == OWN_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ST_WAIT: begin
        // Acks are registered, so they are raised on the way into DONE.
        if (mem_ready || tmr_expired) begin
          state_d  = ST_DONE;
          if_ack_d = (owner_q == OWN_IF);
          d_ack_d  = (owner_q == OWN_D);
          if (!mem_ready) begin
            err_d = 1'b1;
          end
          if (owner_q == OWN_D) begin
            d_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized
// IF/D traffic against a transaction-level model of grants, data and timing.
module tb_mem_port_arbiter;

  localparam int TO    = 16;
  localparam int NEVER = 1000;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        err;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  // Memory responder: ready after a planned delay (or never), stray readies when idle.
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  int force_delay = -1;
  int plan_delay  = 0;
  bit mactive     = 1'b0;
  int mwait       = 0;

  always begin
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (reset) begin
      mactive = 1'b0;
    end else begin
      if (mem_en) begin
        mactive = 1'b1;
        mwait   = 0;
        if (force_delay >= 0)       plan_delay = force_delay;
        else if (force_delay == -2) plan_delay = NEVER;
        else plan_delay = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
      end
      if (mactive) begin
        if (mwait == plan_delay) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            phys_mem[mem_addr] = mem_wdata;
            mem_rdata = ~mem_wdata;
          end else begin
            mem_rdata = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : dflt(mem_addr);
          end
          mactive = 1'b0;
        end else begin
          mwait++;
          if (mwait >= TO) mactive = 1'b0;
        end
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Scoreboard: expected transaction pushed at grant, popped and compared at ack.
  typedef struct {
    bit          own_d;
    bit          we;
    bit          tmo;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  bit          mon_own_d;
  bit          p_if = 1'b0, p_d = 1'b0, p_dwe = 1'b0;
  logic [31:0] p_ifa = '0, p_da = '0, p_dwd = '0;
  bit          last_own_d = 1'b1;
  bit          err_exp = 1'b0;
  logic [31:0] exp_if_rd = '0, exp_d_rd = '0;
  int          last_en_cyc = -100, last_ack_cyc = -100;
  bit          last_en_d = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      last_own_d   = 1'b1;
      err_exp      = 1'b0;
      exp_if_rd    = '0;
      exp_d_rd     = '0;
      last_ack_cyc = -100;
    end else begin
      if (mem_en) begin
        if (p_if && p_d) mon_own_d = RR ? !last_own_d : 1'b1;
        else             mon_own_d = p_d;
        chk("grant_has_req", 64'(p_if | p_d), 64'd1);
        chk("grant_gap", 64'((cyc - last_ack_cyc) >= 2), 64'd1);
        chk("grant_single_outstanding", 64'(sb.size()), 64'd0);
        chk("grant_addr", 64'(mem_addr), 64'(mon_own_d ? p_da : p_ifa));
        chk("grant_we", 64'(mem_we), 64'(mon_own_d && p_dwe));
        if (mon_own_d && p_dwe) chk("grant_wdata", 64'(mem_wdata), 64'(p_dwd));
        mon_e.own_d   = mon_own_d;
        mon_e.we      = mon_own_d && p_dwe;
        mon_e.addr    = mon_own_d ? p_da : p_ifa;
        mon_e.wdata   = p_dwd;
        mon_e.tmo     = (plan_delay == NEVER);
        mon_e.ack_cyc = cyc + (mon_e.tmo ? TO : plan_delay + 1);
        if (mon_e.tmo)     mon_e.data = '0;
        else if (mon_e.we) mon_e.data = ~p_dwd;
        else mon_e.data = ref_mem.exists(mon_e.addr) ? ref_mem[mon_e.addr] : dflt(mon_e.addr);
        sb.push_back(mon_e);
        last_own_d  = mon_own_d;
        last_en_cyc = cyc;
        last_en_d   = mon_own_d;
      end
      if (if_ack || d_ack) begin
        last_ack_cyc = cyc;
        chk("single_ack", 64'(if_ack & d_ack), 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 64'({if_ack, d_ack}), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_owner", 64'(d_ack), 64'(mon_e.own_d));
          chk("ack_cycle", 64'(cyc), 64'(mon_e.ack_cyc));
          if (mon_e.tmo) err_exp = 1'b1;
          chk("err_flag", 64'(err), 64'(err_exp));
          if (mon_e.own_d) begin
            chk("d_rdata", 64'(d_rdata), 64'(mon_e.data));
            chk("if_rdata_hold", 64'(if_rdata), 64'(exp_if_rd));
            exp_d_rd = mon_e.data;
          end else begin
            chk("if_rdata", 64'(if_rdata), 64'(mon_e.data));
            chk("d_rdata_hold", 64'(d_rdata), 64'(exp_d_rd));
            exp_if_rd = mon_e.data;
          end
          if (mon_e.we && !mon_e.tmo) ref_mem[mon_e.addr] = mon_e.wdata;
        end
      end
    end
    p_if  = if_req;
    p_d   = d_req;
    p_dwe = d_we;
    p_ifa = if_addr;
    p_da  = d_addr;
    p_dwd = d_wdata;
  end

  task automatic wait_ack(input bit is_d);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      got = is_d ? d_ack : if_ack;
    end
    chk(is_d ? "d_ack_timeout" : "if_ack_timeout", 64'(got), 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic if_stream(input int n);
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 3) != 0) begin
        if_req = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      if_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      if_req  = 1'b1;
      wait_ack(1'b0);
      @(posedge clk); #1;
    end
    if_req = 1'b0;
  endtask

  task automatic d_stream(input int n);
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 3) != 0) begin
        d_req = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      d_addr  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      d_we    = $urandom_range(0, 1) == 1;
      d_wdata = $urandom;
      d_req   = 1'b1;
      wait_ack(1'b1);
      @(posedge clk); #1;
    end
    d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int ack_c;
    int req_c;
    bit got;
    bit who;
    phys_mem[32'h40] = 32'h8C02_0004;
    ref_mem[32'h40]  = 32'h8C02_0004;
    phys_mem[32'h84] = 32'h1234_5678;
    ref_mem[32'h84]  = 32'h1234_5678;

    // Reset for one cycle, then idle outputs for 10 cycles.
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctrl", 64'({if_ack, d_ack, mem_en, mem_we, err}), 64'd0);
      chk("idle_data", 64'(if_rdata | d_rdata | mem_addr | mem_wdata), 64'd0);
    end

    // Minimum-latency IF fetch.
    force_delay = 0;
    @(posedge clk); #1;
    if_addr = 32'h40; if_req = 1'b1; req_c = cyc;
    wait_ack(1'b0);
    ack_c = cyc;
    chk("t2_mem_en_latency", 64'(last_en_cyc - req_c), 64'd1);
    chk("t2_ack_latency", 64'(ack_c - req_c), 64'd2);
    chk("t2_if_rdata", 64'(if_rdata), 64'h8C02_0004);
    @(posedge clk); #1;
    if_req = 1'b0;
    force_delay = -1;

    pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
    // Both held: grants alternate starting with IF.
    if_addr = 32'h200; d_addr = 32'h204; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0; who = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
        @(negedge clk);
        if (if_ack || d_ack) begin got = 1'b1; who = d_ack; end
      end
      chk("t4_ack_seen", 64'(got), 64'd1);
      chk("t4_grant_order", 64'(who), 64'(g % 2));
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
`else
    // Simultaneous requests: D store wins, IF then reads the stored word.
    if_addr = 32'h100;
    d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; d_req = 1'b1;
    wait_ack(1'b1);
    ack_c = cyc;
    chk("t3_store_latched", 64'(mem_wdata), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    wait_ack(1'b0);
    chk("t3_if_grant_after_d", 64'(last_en_cyc - ack_c), 64'd2);
    chk("t3_if_owner", 64'(last_en_d), 64'd0);
    chk("t3_if_reads_store", 64'(if_rdata), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    if_req = 1'b0;
`endif

    // Watchdog abort on a D load.
    force_delay = -2;
    @(posedge clk); #1;
    d_addr = 32'h300; d_we = 1'b0; d_req = 1'b1;
    wait_ack(1'b1);
    chk("t5_rdata_zero", 64'(d_rdata), 64'd0);
    chk("t5_err_set", 64'(err), 64'd1);
    chk("t5_wait_cycles", 64'(cyc - last_en_cyc), 64'(TO));
    @(posedge clk); #1;
    d_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_err_sticky", 64'(err), 64'd1);

    // Reset in the middle of WAIT, then a fresh fetch.
    @(posedge clk); #1;
    if_addr = 32'h80; if_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = mem_en;
    end
    chk("t6_mem_en_seen", 64'(got), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ctrl_cleared", 64'({if_ack, d_ack, mem_en, mem_we, err}), 64'd0);
    chk("t6_addr_cleared", 64'(mem_addr), 64'd0);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_ack || d_ack) got = 1'b1;
    end
    chk("t6_no_ack_after_reset", 64'(got), 64'd0);
    force_delay = 0;
    @(posedge clk); #1;
    if_addr = 32'h84; if_req = 1'b1;
    wait_ack(1'b0);
    chk("t6_fresh_rdata", 64'(if_rdata), 64'h1234_5678);
    chk("t6_err_clear", 64'(err), 64'd0);
    @(posedge clk); #1;
    if_req = 1'b0;

    // Random concurrent traffic.
    force_delay = -1;
    fork
      if_stream(30);
      d_stream(30);
    join
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
